// File: rtl/sseg_pkg.sv
// Shared constants and payload types for the multiplexed seven-segment scanner.
package sseg_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned BRIGHT_W   = 4;
  localparam int unsigned PWM_STEPS  = 16;

  // Cathodes and anodes are active-low: all ones means dark.
  localparam logic [6:0]            SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

  // Width-independent display controls carried alongside the per-digit vectors.
  typedef struct packed {
    logic [BRIGHT_W-1:0] bright;
    logic                lz_en;
  } scan_ctl_t;

endpackage

// File: rtl/sseg_display.sv
// Hex nibble to active-low seven-segment pattern, seg_c[0] = segment a.
module sseg_display (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (hex)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      default: seg_c = 7'h0E;
    endcase
  end

endmodule

// File: rtl/sseg_scan_n.sv
// N-digit time-multiplexed seven-segment scanner with shadowed frame-synchronous
// updates, 16-level PWM brightness, anode guard time and leading-zero blanking.
module sseg_scan_n
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    lz_en,
  output logic                    busy,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam int unsigned STEP  = SLOT_CYCLES / PWM_STEPS;
  localparam int unsigned HEX_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HEX_W-1:0]      shd_hex_q, act_hex_q;
  logic [NUM_DIGITS-1:0] shd_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0] shd_blank_q, act_blank_q;
  scan_ctl_t             shd_ctl_q, act_ctl_q;
  logic                  busy_d, frame_done_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  logic                  slot_wrap_c, frame_wrap_c, transfer_c;
  logic [NUM_DIGITS-1:0] lz_sup_c;
  logic                  lz_run_c;
  logic [CMP_W-1:0]      cnt_ext_c, pwm_lim_c;
  logic                  dig_on_c;
  logic [3:0]            nib_c;
  logic [6:0]            dec_seg_c;

  assign slot_wrap_c  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign frame_wrap_c = slot_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign transfer_c   = frame_wrap_c && busy;

  // Slot/digit sequencing and shadow handshake.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    busy_d       = busy;
    frame_done_d = frame_wrap_c;
    if (slot_wrap_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (transfer_c) busy_d = 1'b0;
    if (load)       busy_d = 1'b1;
  end

  // A digit is suppressed only if it and every digit above it are a bare zero.
  always_comb begin
    lz_sup_c = '0;
    lz_run_c = act_ctl_q.lz_en;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      lz_run_c    = lz_run_c && (act_hex_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      lz_sup_c[i] = lz_run_c;
    end
  end

  assign cnt_ext_c = CMP_W'(cnt_q);
  assign pwm_lim_c = (CMP_W'(act_ctl_q.bright) + CMP_W'(1)) * CMP_W'(STEP);
  assign dig_on_c  = (cnt_ext_c >= CMP_W'(GUARD_CYCLES)) && (cnt_ext_c < pwm_lim_c) &&
                     !act_blank_q[idx_q] && !lz_sup_c[idx_q];
  assign nib_c     = act_hex_q[{idx_q, 2'b00} +: 4];

  sseg_display u_dec (
    .hex   (nib_c),
    .seg_c (dec_seg_c)
  );

  always_comb begin
    an_d  = AN_OFF[NUM_DIGITS-1:0];
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (dig_on_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dec_seg_c;
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shd_hex_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      shd_ctl_q   <= '0;
      act_hex_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_ctl_q   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      an          <= AN_OFF[NUM_DIGITS-1:0];
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      // Active set takes the pre-load shadow so a boundary-cycle load waits a frame.
      if (transfer_c) begin
        act_hex_q   <= shd_hex_q;
        act_dp_q    <= shd_dp_q;
        act_blank_q <= shd_blank_q;
        act_ctl_q   <= shd_ctl_q;
      end
      if (load) begin
        shd_hex_q   <= hex_in;
        shd_dp_q    <= dp_in;
        shd_blank_q <= blank_in;
        shd_ctl_q   <= '{bright: brightness, lz_en: lz_en};
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_n.sv
// Randomised self-checking bench for sseg_scan_n against a cycle-count reference model.
module tb_sseg_scan_n;

  localparam int N     = 4;
  localparam int S     = 32;
  localparam int G     = 1;
  localparam int FRAME = N * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   hex_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    brightness = '0;
  logic          lz_en = 1'b0;
  logic          busy, frame_done, dp;
  logic [3:0]    an;
  logic [6:0]    seg;

  int checks = 0;
  int errors = 0;

  sseg_scan_n #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .lz_en(lz_en),
    .busy(busy), .frame_done(frame_done), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: position derived from cycles since reset.
  int         m_cyc;
  logic       m_busy, m_fd, m_dp;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic [15:0] sh_hex, ac_hex;
  logic [3:0]  sh_dp, ac_dp, sh_blank, ac_blank, sh_br, ac_br;
  logic        sh_lz, ac_lz;

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int j);
    return v[4*j +: 4];
  endfunction

  function automatic bit lit_at(input int c);
    int slot, d;
    slot = c % S;
    d    = (c / S) % N;
    if (slot < G) return 0;
    if (slot >= (int'(ac_br) + 1) * (S / 16)) return 0;
    if (ac_blank[d]) return 0;
    if (ac_lz && d != 0) begin
      bit allz;
      allz = 1;
      for (int j = d; j < N; j++)
        if (nib(ac_hex, j) != 4'h0 || ac_dp[j]) allz = 0;
      if (allz) return 0;
    end
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_busy <= 1'b0; m_fd <= 1'b0;
      m_an <= 4'hF; m_seg <= 7'h7F; m_dp <= 1'b1;
      sh_hex <= '0; sh_dp <= '0; sh_blank <= '0; sh_br <= '0; sh_lz <= 1'b0;
      ac_hex <= '0; ac_dp <= '0; ac_blank <= '0; ac_br <= '0; ac_lz <= 1'b0;
    end else begin
      m_an  <= lit_at(m_cyc) ? ~(4'b0001 << ((m_cyc / S) % N)) : 4'hF;
      m_seg <= lit_at(m_cyc) ? dec(nib(ac_hex, (m_cyc / S) % N)) : 7'h7F;
      m_dp  <= lit_at(m_cyc) ? ~ac_dp[(m_cyc / S) % N] : 1'b1;
      m_fd  <= (m_cyc % FRAME) == FRAME - 1;
      if ((m_cyc % FRAME) == FRAME - 1 && m_busy) begin
        ac_hex <= sh_hex; ac_dp <= sh_dp; ac_blank <= sh_blank; ac_br <= sh_br; ac_lz <= sh_lz;
      end
      if (load) begin
        sh_hex <= hex_in; sh_dp <= dp_in; sh_blank <= blank_in; sh_br <= brightness; sh_lz <= lz_en;
      end
      m_busy <= load || (m_busy && (m_cyc % FRAME) != FRAME - 1);
      m_cyc  <= m_cyc + 1;
    end
  end

  // Per-frame observations gathered for the scenario tasks to judge.
  int         fs_mism, fs_badslot, fs_fd_cnt, fs_fd_pos;
  int         fs_low [N];
  logic [6:0] fs_seg [N];
  bit         fs_mixed [N];
  logic [3:0] fs_first_an;
  string      fs_msg;

  task automatic align_frame();
    while (m_cyc % FRAME != 0) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                         input logic [3:0] br, input logic lz);
    if (m_cyc % FRAME == FRAME - 1) @(negedge clk);
    hex_in = h; dp_in = d; blank_in = b; brightness = br; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic frame_stats(input int off0, input int off1, input int off2,
                             input logic [15:0] h0, input logic [15:0] h1, input logic [15:0] h2);
    int d;
    fs_mism = 0; fs_badslot = 0; fs_fd_cnt = 0; fs_fd_pos = -1; fs_first_an = 4'hF; fs_msg = "";
    for (int k = 0; k < N; k++) begin fs_low[k] = 0; fs_seg[k] = 7'h7F; fs_mixed[k] = 0; end
    for (int i = 0; i < FRAME; i++) begin
      load = 1'b0;
      if (i == off0)      begin hex_in = h0; load = 1'b1; end
      else if (i == off1) begin hex_in = h1; load = 1'b1; end
      else if (i == off2) begin hex_in = h2; load = 1'b1; end
      @(negedge clk);
      if ({an, seg, dp, busy, frame_done} !== {m_an, m_seg, m_dp, m_busy, m_fd}) begin
        if (fs_mism == 0)
          fs_msg = $sformatf("cyc %0d an %h/%h seg %h/%h dp %b/%b busy %b/%b fd %b/%b", m_cyc,
                             an, m_an, seg, m_seg, dp, m_dp, busy, m_busy, frame_done, m_fd);
        fs_mism++;
      end
      if (frame_done === 1'b1) begin fs_fd_cnt++; fs_fd_pos = i; end
      if (an !== 4'hF) begin
        d = i / S;
        if (an !== ~(4'b0001 << d)) fs_badslot++;
        else begin
          if (fs_first_an == 4'hF) fs_first_an = an;
          fs_low[d]++;
          if (fs_seg[d] == 7'h7F) fs_seg[d] = seg;
          else if (fs_seg[d] !== seg) fs_mixed[d] = 1;
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'hF)     begin errors++; $display("FAIL reset_an: got %h expected f", an); end
    checks++; if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    checks++; if (dp !== 1'b1)     begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
      checks++; if (fs_mism !== 0) begin errors++; $display("FAIL idle_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
      checks++; if (fs_fd_cnt !== 1 || fs_fd_pos !== FRAME - 1) begin
        errors++; $display("FAIL idle_frame_done: got %0d pulses at %0d expected 1 at %0d", fs_fd_cnt, fs_fd_pos, FRAME - 1); end
      checks++; if (fs_badslot !== 0) begin errors++; $display("FAIL idle_slot: got %0d wrong-anode cycles expected 0", fs_badslot); end
      for (int k = 0; k < N; k++) begin
        checks++; if (fs_low[k] !== 1 || fs_seg[k] !== dec(4'h0)) begin
          errors++; $display("FAIL idle_digit%0d: got %0d cycles seg %h expected 1 cycle seg %h", k, fs_low[k], fs_seg[k], dec(4'h0)); end
      end
    end
  endtask

  task automatic test_load_full();
    do_load(16'h1234, 4'h0, 4'h0, 4'd15, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_load: got %b expected 1", busy); end
    while (m_cyc % FRAME != FRAME - 1) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_held: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b expected 0", busy); end
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL full_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    checks++; if (fs_first_an !== 4'hE || fs_badslot !== 0) begin
      errors++; $display("FAIL full_order: got first an %h, %0d wrong-anode cycles expected e, 0", fs_first_an, fs_badslot); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_low[k] !== 31 || fs_seg[k] !== dec(4'(k + 1) ^ 4'h0) && k == 3) ;
      if (fs_low[k] !== 31 || fs_seg[k] !== dec(nib(16'h1234, k))) begin
        errors++; $display("FAIL full_digit%0d: got %0d cycles seg %h expected 31 seg %h", k, fs_low[k], fs_seg[k], dec(nib(16'h1234, k))); end
    end
  endtask

  task automatic test_brightness();
    do_load(16'h1234, 4'h0, 4'h0, 4'd3, 1'b0);
    align_frame();
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL pwm_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_low[k] !== 7) begin errors++; $display("FAIL pwm_digit%0d: got %0d cycles expected 7", k, fs_low[k]); end
    end
  endtask

  task automatic test_leading_zero();
    int want [N];
    do_load(16'h0050, 4'b0000, 4'h0, 4'd15, 1'b1);
    align_frame();
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    want = '{31, 31, 0, 0};
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL lz_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_low[k] !== want[k]) begin errors++; $display("FAIL lz_digit%0d: got %0d cycles expected %0d", k, fs_low[k], want[k]); end
    end
    do_load(16'h0050, 4'b0100, 4'h0, 4'd15, 1'b1);
    align_frame();
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL lzdp_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    checks++; if (fs_low[2] !== 31 || fs_seg[2] !== dec(4'h0) || fs_low[3] !== 0) begin
      errors++; $display("FAIL lzdp_digits: got d2 %0d cycles seg %h d3 %0d expected 31 seg %h 0", fs_low[2], fs_seg[2], fs_low[3], dec(4'h0)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    bit mixed;
    r = 16'($urandom);
    dp_in = '0; blank_in = '0; brightness = 4'd15; lz_en = 1'b0;
    align_frame();
    frame_stats(10, 50, FRAME - 1, 16'hAAAA, 16'hBBBB, r);
    mixed = 0; for (int k = 0; k < N; k++) mixed |= fs_mixed[k];
    checks++; if (fs_mism !== 0 || mixed) begin errors++; $display("FAIL b2b_old: %0d bad cycles mixed %b, first %s", fs_mism, mixed, fs_msg); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_boundary: got %b expected 1", busy); end
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL b2b_bbbb_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_seg[k] !== dec(4'hB) || fs_mixed[k]) begin
        errors++; $display("FAIL b2b_bbbb_digit%0d: got seg %h mixed %b expected %h", k, fs_seg[k], fs_mixed[k], dec(4'hB)); end
    end
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_last_model: %0d bad cycles busy %b, first %s", fs_mism, busy, fs_msg); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_seg[k] !== dec(nib(r, k))) begin
        errors++; $display("FAIL b2b_last_digit%0d: got seg %h expected %h", k, fs_seg[k], dec(nib(r, k))); end
    end
  endtask

  task automatic test_random();
    logic [15:0] h1, h2;
    int o1, o2;
    bit mixed;
    for (int it = 0; it < 8; it++) begin
      dp_in      = 4'($urandom);
      blank_in   = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      brightness = 4'($urandom);
      lz_en      = 1'($urandom);
      for (int k = 0; k < N; k++) begin
        h1[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
        h2[4*k +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      end
      o1 = $urandom_range(0, FRAME - 1);
      o2 = ($urandom % 2 == 0) ? $urandom_range(0, FRAME - 1) : -1;
      frame_stats(o1, o2, -1, h1, h2, 16'h0);
      mixed = 0; for (int k = 0; k < N; k++) mixed |= fs_mixed[k];
      checks++; if (fs_mism !== 0 || fs_badslot !== 0 || mixed) begin
        errors++; $display("FAIL random_%0d: %0d bad cycles, %0d wrong-anode, mixed %b, first %s", it, fs_mism, fs_badslot, mixed, fs_msg); end
    end
  endtask

  task automatic test_async_reset();
    do_load(16'h1234, 4'h0, 4'h0, 4'd15, 1'b0);
    align_frame();
    do_load(16'h9876, 4'h0, 4'h0, 4'd15, 1'b0);
    while (m_cyc % S != 15) @(negedge clk);
    checks++; if (an === 4'hF || busy !== 1'b1) begin errors++; $display("FAIL pre_reset: got an %h busy %b expected lit, busy 1", an, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset_out: got an %h seg %h dp %b fd %b expected f 7f 1 0", an, seg, dp, frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    frame_stats(-1, -1, -1, 16'h0, 16'h0, 16'h0);
    checks++; if (fs_mism !== 0) begin errors++; $display("FAIL post_reset_model: %0d bad cycles, first %s", fs_mism, fs_msg); end
    checks++; if (fs_first_an !== 4'hE) begin errors++; $display("FAIL post_reset_first: got an %h expected e", fs_first_an); end
    for (int k = 0; k < N; k++) begin
      checks++; if (fs_low[k] !== 1 || fs_seg[k] !== dec(4'h0)) begin
        errors++; $display("FAIL post_reset_digit%0d: got %0d cycles seg %h expected 1 seg %h", k, fs_low[k], fs_seg[k], dec(4'h0)); end
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_brightness();
    test_leading_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
